// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared LFSR tap table, draw FSM state type and width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } draw_state_e;

  localparam int C_TAPS_MIN_W = 4;
  localparam int C_TAPS_MAX_W = 16;

  // Maximal-length Fibonacci tap masks, bit i set means state[i] feeds the XOR.
  function automatic logic [15:0] taps(input int width);
    case (width)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
  endfunction

  // Number of bits needed to hold a value in [0, range-1].
  function automatic int out_w(input int range);
    out_w = (range < 2) ? 1 : $clog2(range);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_core
//  Description : Fibonacci LFSR register with seed load and zero-state guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 9,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [15:0]      C_TAPS_FULL = taps(WIDTH);
  localparam logic [WIDTH-1:0] C_TAPS      = C_TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             w_fb;

  assign w_fb = ^(state_q & C_TAPS);

  // Next state: load beats everything; an all-zero state is always replaced by SEED.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (load_val_i == '0) ? SEED : load_val_i;
    end else if (state_q == '0) begin
      state_d = SEED;
    end else if (step_i) begin
      state_d = {state_q[WIDTH-2:0], w_fb};
    end
  end

  // State register, returns to SEED on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_draw_rng.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_draw_rng
//  Description : Free-running LFSR with a ready/valid bounded-range draw engine
//                using rejection sampling and a forced fold-down fallback.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_draw_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 9,
  parameter int               RANGE     = 52,
  parameter int               OUT_W     = out_w(RANGE),
  parameter logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               MAX_TRIES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  input  logic             draw_req_i,
  output logic             draw_ready_o,
  output logic             draw_valid_o,
  output logic [OUT_W-1:0] draw_value_o,
  output logic [4:0]       draw_tries_o,
  output logic [WIDTH-1:0] rnd_o
);

  localparam logic [OUT_W:0]   C_RANGE_EXT = (OUT_W+1)'(RANGE);
  localparam logic [OUT_W-1:0] C_RANGE_LO  = OUT_W'(RANGE);
  localparam logic [4:0]       C_MAX_TRIES = 5'(MAX_TRIES);

  draw_state_e      state_q, state_d;
  logic [4:0]       tries_q, tries_d;
  logic [4:0]       out_tries_q, out_tries_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             w_step;
  logic             w_load;
  logic [WIDTH-1:0] w_state;
  logic [OUT_W-1:0] w_s;
  logic             w_in_range;
  logic [OUT_W-1:0] w_fold;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .step_i     (w_step),
    .load_i     (w_load),
    .load_val_i (seed_in_i),
    .state_o    (w_state)
  );

  // Low bits are the candidate; RANGE exceeds half the window, so one subtract folds it in.
  assign w_s        = w_state[OUT_W-1:0];
  assign w_in_range = ({1'b0, w_s} < C_RANGE_EXT);
  assign w_fold     = w_s - C_RANGE_LO;

  // Draw FSM next-state, LFSR control and result capture.
  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    out_tries_d = out_tries_q;
    value_d     = value_q;
    w_step      = 1'b0;
    w_load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_load_i) begin
          w_load = 1'b1;
        end else if (draw_req_i) begin
          state_d = SAMPLE;
          tries_d = '0;
        end else if (en_i) begin
          w_step = 1'b1;
        end
      end
      SAMPLE: begin
        w_step = 1'b1;
        if (w_in_range) begin
          value_d     = w_s;
          out_tries_d = tries_q;
          state_d     = DONE;
        end else if (tries_q == C_MAX_TRIES) begin
          value_d     = w_fold;
          out_tries_d = tries_q;
          state_d     = DONE;
        end else begin
          tries_d = (tries_q == 5'd31) ? tries_q : tries_q + 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and result registers; a reset mid-draw simply abandons the draw.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      tries_q     <= '0;
      out_tries_q <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      out_tries_q <= out_tries_d;
      value_q     <= value_d;
    end
  end

  assign draw_ready_o = (state_q == IDLE);
  assign draw_valid_o = (state_q == DONE);
  assign draw_value_o = value_q;
  assign draw_tries_o = out_tries_q;
  assign rnd_o        = w_state;

endmodule
`default_nettype wire
